lsu: RTL

//  Load/store + write-back stage directly downstream of EX. Captures the LSU op EX drives combinationally,

---
 rtl/utils_pkg.sv | 61 ++++++
 rtl/lsu_align.sv | 53 +++++
 rtl/lsu.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/utils_pkg.sv
// Shared types and constants for the load/store unit.
// Op bundle, trap info, FSM states, cause codes, width encodings.
package utils_pkg;

   typedef enum logic [1:0] {
      LSU_NONE  = 2'd0,
      LSU_LOAD  = 2'd1,
      LSU_STORE = 2'd2
   } lsu_op_typ_t;

   typedef enum logic [1:0] {
      LSU_IDLE = 2'd0,
      LSU_REQ  = 2'd1,
      LSU_WAIT = 2'd2
   } lsu_fsm_t;

   typedef enum logic [2:0] {
      F3_B  = 3'b000,
      F3_H  = 3'b001,
      F3_W  = 3'b010,
      F3_BU = 3'b100,
      F3_HU = 3'b101
   } ld_width_e;

   typedef struct packed {
      lsu_op_typ_t op_typ;
      logic [2:0]  width;
      logic [31:0] addr;
      logic [31:0] wdata;
   } s_lsu_op_t;

   typedef struct packed {
      logic [31:0] result;
      logic [4:0]  rd_addr;
      logic        we_rd;
   } s_ex_mem_wb_t;

   typedef struct packed {
      logic [31:0] mcause;
      logic [31:0] mtval;
   } s_trap_info_t;

   localparam logic [31:0] CAUSE_LD_MISALIGN = 32'd4;
   localparam logic [31:0] CAUSE_LD_ACCESS   = 32'd5;
   localparam logic [31:0] CAUSE_ST_MISALIGN = 32'd6;
   localparam logic [31:0] CAUSE_ST_ACCESS   = 32'd7;

   // Size bits of funct3: 01 = half, 10 = word.
   function automatic logic misaligned(input logic [1:0] sz,
                                       input logic [1:0] a);
      logic m;
      m = 1'b0;
      case (sz)
         2'b01:   m = a[0];
         2'b10:   m = |a;
         default: m = 1'b0;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the load/store unit.
// Extracts/extends load data and builds store strobes/lanes.
module lsu_align
   import utils_pkg::*;
(
   input  logic [2:0]  width_i,
   input  logic [1:0]  off_i,
   input  logic [31:0] rdata_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] ld_data_o,
   output logic [3:0]  wstrb_o,
   output logic [31:0] wdata_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   assign byte_sel = rdata_i[8*off_i +: 8];
   assign half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];

   // Load lane select plus sign/zero extension
   always_comb begin
      ld_data_o = rdata_i;
      case (width_i)
         F3_B:    ld_data_o = {{24{byte_sel[7]}}, byte_sel};
         F3_H:    ld_data_o = {{16{half_sel[15]}}, half_sel};
         F3_BU:   ld_data_o = {24'h0, byte_sel};
         F3_HU:   ld_data_o = {16'h0, half_sel};
         default: ld_data_o = rdata_i;
      endcase
   end

   // Store strobes and lane replication
   always_comb begin
      wstrb_o = 4'hF;
      wdata_o = wdata_i;
      case (width_i[1:0])
         2'b00: begin
            wstrb_o = 4'b0001 << off_i;
            wdata_o = {4{wdata_i[7:0]}};
         end
         2'b01: begin
            wstrb_o = 4'b0011 << off_i;
            wdata_o = {2{wdata_i[15:0]}};
         end
         default: begin
            wstrb_o = 4'hF;
            wdata_o = wdata_i;
         end
      endcase
   end

endmodule

// File: rtl/lsu.sv
// Load/store + write-back stage behind EX.
// One bus transaction at a time; stalls EX while busy.
module lsu
   import utils_pkg::*;
#(
   parameter int unsigned MAX_WAIT_CYCLES = 0
)(
   input  logic         clk,
   input  logic         rst,
   input  s_lsu_op_t    lsu_i,
   input  s_ex_mem_wb_t ex_mem_wb_i,
   output logic         lsu_bp_o,
   output logic [31:0]  wb_value_o,
   output logic [4:0]   rd_addr_o,
   output logic         we_rd_o,
   output logic         data_req_valid_o,
   input  logic         data_req_ready_i,
   output logic [31:0]  data_req_addr_o,
   output logic         data_req_we_o,
   output logic [3:0]   data_req_wstrb_o,
   output logic [31:0]  data_req_wdata_o,
   input  logic         data_resp_valid_i,
   input  logic [31:0]  data_resp_rdata_i,
   input  logic         data_resp_err_i,
   output logic         lsu_trap_o,
   output s_trap_info_t lsu_trap_info_o
);

   lsu_fsm_t     state_q;
   s_lsu_op_t    op_q;
   logic         req_valid_q;
   logic [31:0]  wait_cnt_q;
   logic         ld_pending_q;
   logic [31:0]  ld_data_q;
   logic         trap_q;
   s_trap_info_t trap_info_q;

   logic        is_mem;
   logic        misal;
   logic        accept;
   logic        fault_in;
   logic        timeout;
   logic        resp_done;
   logic        resp_err;
   logic        is_store_q;
   logic [31:0] ld_aligned;
   logic [3:0]  st_strb;
   logic [31:0] st_data;

   lsu_align u_align (
      .width_i   (op_q.width),
      .off_i     (op_q.addr[1:0]),
      .rdata_i   (data_resp_rdata_i),
      .wdata_i   (op_q.wdata),
      .ld_data_o (ld_aligned),
      .wstrb_o   (st_strb),
      .wdata_o   (st_data)
   );

   assign is_mem   = (lsu_i.op_typ == LSU_LOAD) ||
                     (lsu_i.op_typ == LSU_STORE);
   assign misal    = misaligned(lsu_i.width[1:0], lsu_i.addr[1:0]);
   assign accept   = !rst && (state_q == LSU_IDLE) && is_mem && !misal;
   assign fault_in = (state_q == LSU_IDLE) && is_mem && misal;

   assign timeout   = (MAX_WAIT_CYCLES != 0) &&
                      (wait_cnt_q == 32'(MAX_WAIT_CYCLES));
   assign resp_done = (state_q == LSU_WAIT) &&
                      (data_resp_valid_i || timeout);
   assign resp_err  = data_resp_valid_i ? data_resp_err_i : timeout;

   assign is_store_q = (op_q.op_typ == LSU_STORE);

   assign lsu_bp_o = !rst && (accept || (state_q == LSU_REQ) ||
                     ((state_q == LSU_WAIT) && !resp_done));

   assign data_req_valid_o = req_valid_q;
   assign data_req_addr_o  = req_valid_q ? {op_q.addr[31:2], 2'b00} : 32'h0;
   assign data_req_we_o    = req_valid_q && is_store_q;
   assign data_req_wstrb_o = (req_valid_q && is_store_q) ? st_strb : 4'h0;
   assign data_req_wdata_o = (req_valid_q && is_store_q) ? st_data : 32'h0;

   assign wb_value_o = ld_pending_q ? ld_data_q : ex_mem_wb_i.result;
   assign rd_addr_o  = ex_mem_wb_i.rd_addr;
   assign we_rd_o    = ex_mem_wb_i.we_rd && !trap_q &&
                       (ex_mem_wb_i.rd_addr != 5'd0);

   assign lsu_trap_o      = trap_q;
   assign lsu_trap_info_o = trap_info_q;

   // Transaction FSM with registered bus request, load data and trap pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= LSU_IDLE;
         op_q         <= '0;
         req_valid_q  <= 1'b0;
         wait_cnt_q   <= 32'h0;
         ld_pending_q <= 1'b0;
         ld_data_q    <= 32'h0;
         trap_q       <= 1'b0;
         trap_info_q  <= '0;
      end else begin
         ld_pending_q <= 1'b0;
         trap_q       <= 1'b0;
         unique case (state_q)
            LSU_IDLE: begin
               if (accept) begin
                  op_q        <= lsu_i;
                  req_valid_q <= 1'b1;
                  wait_cnt_q  <= 32'h0;
                  state_q     <= LSU_REQ;
               end else if (fault_in) begin
                  trap_q             <= 1'b1;
                  trap_info_q.mcause <= (lsu_i.op_typ == LSU_STORE) ?
                                        CAUSE_ST_MISALIGN :
                                        CAUSE_LD_MISALIGN;
                  trap_info_q.mtval  <= lsu_i.addr;
               end
            end
            LSU_REQ: begin
               if (data_req_ready_i) begin
                  req_valid_q <= 1'b0;
                  state_q     <= LSU_WAIT;
               end
            end
            LSU_WAIT: begin
               if (resp_done) begin
                  state_q    <= LSU_IDLE;
                  wait_cnt_q <= 32'h0;
                  if (resp_err) begin
                     trap_q             <= 1'b1;
                     trap_info_q.mcause <= is_store_q ? CAUSE_ST_ACCESS :
                                           CAUSE_LD_ACCESS;
                     trap_info_q.mtval  <= op_q.addr;
                  end else if (!is_store_q) begin
                     ld_data_q    <= ld_aligned;
                     ld_pending_q <= 1'b1;
                  end
               end else begin
                  wait_cnt_q <= wait_cnt_q + 32'h1;
               end
            end
            default: state_q <= LSU_IDLE;
         endcase
      end
   end

endmodule
